// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled start/data/parity/stop sampling and a show-ahead receive FIFO.
// Sticky framing, parity and overrun flags; config is captured at start detect and held for the frame.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVS        = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          rx,
    input  logic                          en,
    input  logic [DIV_W-1:0]              prescaler,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          stop2,
    input  logic                          rd,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rdata,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    localparam logic [4:0]  TICK_HALF = 5'(OVS / 2 - 1);
    localparam logic [4:0]  TICK_FULL = 5'(OVS - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [PW:0] DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

    // Expected parity bit for a data word: even parity makes the total XOR zero.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic                 sync1_r, sync2_r, rx_prev_r, rx_s, fall_s;
    logic [2:0]           state_r, state_s;
    logic [DIV_W-1:0]     pre_cnt_r, pre_cnt_s, div_q_r;
    logic [4:0]           tick_cnt_r, tick_cnt_s;
    logic [3:0]           bit_cnt_r, bit_cnt_s;
    logic                 stop_idx_r, stop_idx_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 par_en_q_r, par_odd_q_r, stop2_q_r;
    logic                 par_bad_r, par_bad_s, frm_bad_r, frm_bad_s, frm_last_s;
    logic                 tick_s, start_s, push_req_s, set_frm_s, set_par_s;

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [PW:0]          count_r, count_s;
    logic                 pop_s, push_s, ovr_s;
    logic [DATA_BITS-1:0] rdata_r, rdata_s;
    logic                 empty_r, full_r;
    logic                 frame_err_r, parity_err_r, overrun_err_r;
    logic                 frame_err_s, parity_err_s, overrun_err_s;

    assign rx_s = sync2_r;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= rx;
            sync2_r   <= sync1_r;
            rx_prev_r <= sync2_r;
        end
    end

    // Receive FSM next-state, oversample tick and bit sampling.
    always_comb begin
        state_s    = state_r;
        pre_cnt_s  = pre_cnt_r;
        tick_cnt_s = tick_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        stop_idx_s = stop_idx_r;
        shift_s    = shift_r;
        par_bad_s  = par_bad_r;
        frm_bad_s  = frm_bad_r;
        frm_last_s = 1'b0;
        tick_s     = 1'b0;
        start_s    = 1'b0;
        push_req_s = 1'b0;
        set_frm_s  = 1'b0;
        set_par_s  = 1'b0;
        fall_s     = rx_prev_r & ~rx_s;
        if (!en) begin
            state_s   = ST_IDLE;
            pre_cnt_s = '0;
        end else if (state_r == ST_IDLE) begin
            if (fall_s) begin
                start_s    = 1'b1;
                state_s    = ST_START;
                pre_cnt_s  = '0;
                tick_cnt_s = 5'd0;
                bit_cnt_s  = 4'd0;
                stop_idx_s = 1'b0;
                par_bad_s  = 1'b0;
                frm_bad_s  = 1'b0;
            end else begin
                state_s = ST_IDLE;
            end
        end else begin
            if (pre_cnt_r == div_q_r) begin
                tick_s     = 1'b1;
                pre_cnt_s  = '0;
                tick_cnt_s = tick_cnt_r + 5'd1;
            end else begin
                pre_cnt_s  = pre_cnt_r + DIV_W'(1);
            end
            case (state_r)
                ST_START: begin
                    if (tick_s && (tick_cnt_r == TICK_HALF)) begin
                        tick_cnt_s = 5'd0;
                        state_s    = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        state_s = ST_START;
                    end
                end
                ST_DATA: begin
                    if (tick_s && (tick_cnt_r == TICK_FULL)) begin
                        tick_cnt_s = 5'd0;
                        shift_s    = {rx_s, shift_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_s = 4'd0;
                            state_s   = par_en_q_r ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_s = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (tick_s && (tick_cnt_r == TICK_FULL)) begin
                        tick_cnt_s = 5'd0;
                        par_bad_s  = (rx_s != parity_of(shift_r, par_odd_q_r));
                        state_s    = ST_STOP;
                    end else begin
                        state_s = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    if (tick_s && (tick_cnt_r == TICK_FULL)) begin
                        tick_cnt_s = 5'd0;
                        if (stop2_q_r && !stop_idx_r) begin
                            stop_idx_s = 1'b1;
                            frm_bad_s  = frm_bad_r | ~rx_s;
                        end else begin
                            // A line still low at the last stop sample is a break: wait for idle.
                            frm_last_s = frm_bad_r | ~rx_s;
                            set_frm_s  = frm_last_s;
                            set_par_s  = par_bad_r;
                            push_req_s = ~frm_last_s & ~par_bad_r;
                            state_s    = (frm_last_s && !rx_s) ? ST_WAIT_HIGH : ST_IDLE;
                        end
                    end else begin
                        state_s = ST_STOP;
                    end
                end
                ST_WAIT_HIGH: begin
                    state_s = rx_s ? ST_IDLE : ST_WAIT_HIGH;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Receive FSM state and per-frame configuration capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            pre_cnt_r   <= '0;
            tick_cnt_r  <= 5'd0;
            bit_cnt_r   <= 4'd0;
            stop_idx_r  <= 1'b0;
            shift_r     <= '0;
            par_bad_r   <= 1'b0;
            frm_bad_r   <= 1'b0;
            div_q_r     <= '0;
            par_en_q_r  <= 1'b0;
            par_odd_q_r <= 1'b0;
            stop2_q_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pre_cnt_r  <= pre_cnt_s;
            tick_cnt_r <= tick_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            stop_idx_r <= stop_idx_s;
            shift_r    <= shift_s;
            par_bad_r  <= par_bad_s;
            frm_bad_r  <= frm_bad_s;
            if (start_s) begin
                div_q_r     <= prescaler;
                par_en_q_r  <= parity_en;
                par_odd_q_r <= parity_odd;
                stop2_q_r   <= stop2;
            end
        end
    end

    // FIFO push/pop arbitration, next show-ahead head word and sticky flag updates.
    always_comb begin
        pop_s   = rd & (count_r != '0);
        push_s  = push_req_s & ((count_r != DEPTH_C) | pop_s);
        ovr_s   = push_req_s & ~push_s;
        count_s = count_r + (PW + 1)'(push_s) - (PW + 1)'(pop_s);
        if (count_s == '0) begin
            rdata_s = '0;
        end else if (pop_s) begin
            rdata_s = (count_r > (PW + 1)'(1)) ? mem_r[rd_ptr_r + PW'(1)] : shift_r;
        end else if (count_r == '0) begin
            rdata_s = shift_r;
        end else begin
            rdata_s = rdata_r;
        end
        frame_err_s   = set_frm_s ? 1'b1 : (clr_err ? 1'b0 : frame_err_r);
        parity_err_s  = set_par_s ? 1'b1 : (clr_err ? 1'b0 : parity_err_r);
        overrun_err_s = ovr_s     ? 1'b1 : (clr_err ? 1'b0 : overrun_err_r);
    end

    // FIFO storage; contents need no reset since the head is held in rdata_r.
    always_ff @(posedge HCLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end
    end

    // FIFO pointers, status outputs and sticky error flags.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            rdata_r       <= '0;
            empty_r       <= 1'b1;
            full_r        <= 1'b0;
            frame_err_r   <= 1'b0;
            parity_err_r  <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r       <= count_s;
            rdata_r       <= rdata_s;
            empty_r       <= (count_s == '0);
            full_r        <= (count_s == DEPTH_C);
            frame_err_r   <= frame_err_s;
            parity_err_r  <= parity_err_s;
            overrun_err_r <= overrun_err_s;
        end
    end

    assign rdata       = rdata_r;
    assign empty       = empty_r;
    assign full        = full_r;
    assign level       = count_r;
    assign frame_err   = frame_err_r;
    assign parity_err  = parity_err_r;
    assign overrun_err = overrun_err_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame-level reference model (push cycle from bit arithmetic, queue FIFO,
// sticky flags) compared every cycle, plus directed literal checks.
module tb_uart_rx_fifo;

    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int OVS   = 16;
    localparam int DW    = 16;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          rx = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] prescaler = '0;
    logic          parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
    logic          rd_dir = 1'b0, rd_rnd = 1'b0, clr_dir = 1'b0, clr_rnd = 1'b0;
    logic          rd, clr_err;
    logic [DB-1:0] rdata;
    logic          empty, full, frame_err, parity_err, overrun_err;
    logic [2:0]    level;

    assign rd      = rd_dir | rd_rnd;
    assign clr_err = clr_dir | clr_rnd;

    always #5 HCLK = ~HCLK;

    uart_rx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .OVS(OVS), .DIV_W(DW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx), .en(en), .prescaler(prescaler),
        .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2), .rd(rd), .clr_err(clr_err),
        .rdata(rdata), .empty(empty), .full(full), .level(level),
        .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
    );

    typedef struct {
        int         cyc;
        logic [7:0] d;
        bit         frm;
        bit         par;
    } ev_t;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         rnd_on = 1'b0;
    logic [7:0] mq[$];
    ev_t        pend[$];
    bit         m_fe = 1'b0, m_pe = 1'b0, m_oe = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: frame outcomes land at their computed cycle; FIFO is a queue.
    initial begin
        bit         ev, pop, push_ok, ovr, rd_v, clr_v;
        ev_t        e;
        logic [7:0] exp_rd;
        forever begin
            @(posedge HCLK);
            cyc++;
            rd_v  = rd;
            clr_v = clr_err;
            if (!HRESETn) begin
                mq.delete();
                pend.delete();
                m_fe = 1'b0; m_pe = 1'b0; m_oe = 1'b0;
            end else begin
                ev = 1'b0;
                while (pend.size() > 0 && pend[0].cyc < cyc) void'(pend.pop_front());
                if (pend.size() > 0 && pend[0].cyc == cyc) begin
                    e  = pend.pop_front();
                    ev = 1'b1;
                end
                pop     = rd_v && (mq.size() > 0);
                push_ok = ev && !e.frm && !e.par;
                ovr     = push_ok && (mq.size() == DEPTH) && !pop;
                m_fe = (ev && e.frm) ? 1'b1 : (clr_v ? 1'b0 : m_fe);
                m_pe = (ev && e.par) ? 1'b1 : (clr_v ? 1'b0 : m_pe);
                m_oe = ovr ? 1'b1 : (clr_v ? 1'b0 : m_oe);
                if (pop) void'(mq.pop_front());
                if (push_ok && !ovr) mq.push_back(e.d);
            end
            #1;
            exp_rd = (mq.size() > 0) ? mq[0] : 8'h00;
            checks++;
            if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
                level !== 3'(mq.size()) || rdata !== exp_rd ||
                frame_err !== m_fe || parity_err !== m_pe || overrun_err !== m_oe) begin
                failures++;
                $display("FAIL outputs cyc=%0d got e=%b f=%b lvl=%0d rd=%h fe=%b pe=%b oe=%b exp e=%b f=%b lvl=%0d rd=%h fe=%b pe=%b oe=%b",
                         cyc, empty, full, level, rdata, frame_err, parity_err, overrun_err,
                         mq.size() == 0, mq.size() == DEPTH, mq.size(), exp_rd, m_fe, m_pe, m_oe);
            end
        end
    end

    // Random pop / flag-clear pulses during the randomized phase.
    initial begin
        forever begin
            @(negedge HCLK);
            if (rnd_on) begin
                rd_rnd  = ($urandom_range(0, 39) == 0);
                clr_rnd = ($urandom_range(0, 299) == 0);
            end else begin
                rd_rnd  = 1'b0;
                clr_rnd = 1'b0;
            end
        end
    end

    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Drive one frame; abort_at>0 stops after that many cycles and predicts nothing.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit po, input bit s2,
                              input bit bad_par, input bit [1:0] bad_stop, input int hold_low,
                              input int abort_at);
        logic bits[$];
        int   bitlen, c, k, n;
        ev_t  e;
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ po ^ bad_par);
        bits.push_back(~bad_stop[0]);
        if (s2) bits.push_back(~bad_stop[1]);
        bitlen = OVS * (p + 1);
        @(negedge HCLK);
        prescaler  = DW'(p);
        parity_en  = pe;
        parity_odd = po;
        stop2      = s2;
        c = cyc;
        k = OVS / 2 + OVS * (DB + (pe ? 1 : 0) + (s2 ? 2 : 1));
        if (abort_at == 0) begin
            e.cyc = c + 3 + k * (p + 1);
            e.d   = d;
            e.frm = bad_stop[0] | (s2 & bad_stop[1]);
            e.par = pe & bad_par;
            pend.push_back(e);
        end
        n = 0;
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (bitlen) begin
                if (abort_at > 0 && n == abort_at) return;
                @(negedge HCLK);
                n++;
            end
        end
        if (hold_low > 0) begin
            rx = 1'b0;
            repeat (hold_low * bitlen) @(negedge HCLK);
        end
        rx = 1'b1;
        repeat (bitlen + $urandom_range(0, 7)) @(negedge HCLK);
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        @(negedge HCLK);
        chk(name, rdata, exp);
        rd_dir = 1'b1;
        @(negedge HCLK);
        rd_dir = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge HCLK);
        clr_dir = 1'b1;
        @(negedge HCLK);
        clr_dir = 1'b0;
    endtask

    initial begin
        int         c0;
        logic [7:0] d;
        int         p;
        bit         pe, po, s2, bp;
        logic [1:0] bs;
        int         hl;

        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_level", level, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_flags", {frame_err, parity_err, overrun_err}, 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        en      = 1'b1;
        repeat (5) @(negedge HCLK);

        // 0x55, 8N1, prescaler 0: push lands 152 ticks after start detect
        fork
            send_frame(8'h55, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
            begin
                @(negedge HCLK);
                c0 = cyc;
                do begin @(posedge HCLK); #1; end while (cyc != c0 + 3 + 152 - 1);
                chk("t040_before_push_empty", empty, 1);
                @(posedge HCLK);
                #1;
                chk("t040_push_empty", empty, 0);
                chk("t040_rdata", rdata, 8'h55);
                chk("t040_level", level, 1);
            end
        join
        pop_chk("t040_pop", 8'h55);
        chk("t040_empty_after_pop", empty, 1);

        send_frame(8'hA3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 0, 0);
        chk("t041_parity_err", parity_err, 1);
        chk("t041_empty", empty, 1);
        clear_flags();
        chk("t041_cleared", parity_err, 0);

        send_frame(8'h5A, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 40, 0);
        chk("t042_frame_err", frame_err, 1);
        chk("t042_empty", empty, 1);
        send_frame(8'h3C, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        chk("t042_next_rdata", rdata, 8'h3C);
        chk("t042_next_level", level, 1);
        pop_chk("t042_pop", 8'h3C);
        clear_flags();

        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        chk("t043_full", full, 1);
        chk("t043_level", level, 4);
        chk("t043_overrun", overrun_err, 1);
        for (int i = 1; i <= 4; i++) pop_chk("t043_pop", 8'(i));
        chk("t043_empty", empty, 1);
        clear_flags();

        @(negedge HCLK);
        prescaler = '0;
        rx = 1'b0;
        repeat (3) @(negedge HCLK);
        rx = 1'b1;
        repeat (40) @(negedge HCLK);
        chk("t044_empty", empty, 1);
        chk("t044_flags", {frame_err, parity_err, overrun_err}, 0);

        send_frame(8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 88);
        HRESETn = 1'b0;
        rx      = 1'b1;
        repeat (4) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (20) @(negedge HCLK);
        send_frame(8'h7E, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
        chk("t045_level", level, 1);
        chk("t045_rdata", rdata, 8'h7E);
        pop_chk("t045_pop", 8'h7E);

        send_frame(8'hC3, 1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 100);
        en = 1'b0;
        rx = 1'b1;
        repeat (5) @(negedge HCLK);
        en = 1'b1;
        repeat (10) @(negedge HCLK);
        chk("en_abort_empty", empty, 1);
        send_frame(8'h99, 0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 0, 0);
        chk("en_resume_rdata", rdata, 8'h99);
        chk("en_resume_level", level, 1);
        pop_chk("en_resume_pop", 8'h99);

        rnd_on = 1'b1;
        for (int i = 0; i < 40; i++) begin
            d  = 8'($urandom);
            p  = $urandom_range(0, 2);
            pe = 1'($urandom);
            po = 1'($urandom);
            s2 = 1'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hl = ((s2 ? bs[1] : bs[0]) && $urandom_range(0, 1) == 1) ? 2 : 0;
            send_frame(d, p, pe, po, s2, bp, bs, hl, 0);
        end
        rnd_on = 1'b0;
        repeat (4) @(negedge HCLK);
        for (int i = 0; i < DEPTH + 2; i++) begin
            @(negedge HCLK);
            rd_dir = (mq.size() > 0);
            @(negedge HCLK);
            rd_dir = 1'b0;
        end
        chk("drain_empty", empty, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
